// File: rtl/display_mux_regs.sv
// Port-mapped multiplexed seven-segment controller for 1..8 digits.
// Define DISPLAY_MUX_BRIGHTNESS_EN to add the BRIGHT register and per-slot duty gating.
module display_mux_regs #(
    parameter logic [7:0]  BASE_ADDRESS = 8'h00,
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SCAN_DIV     = 50000,
    parameter bit          ACTIVE_LOW   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            port_id,
    input  logic [7:0]            data_in,
    output logic [7:0]            data_out,
    input  logic                  read_strobe,
    input  logic                  write_strobe,
    output logic [7:0]            segments,
    output logic [NUM_DIGITS-1:0] anodes
);

    localparam int unsigned PW = $clog2(SCAN_DIV);

    logic [7:0]            digit [8];
    logic                  en;
    logic                  decode;
    logic [NUM_DIGITS-1:0] blank;
    logic [PW-1:0]         presc;
    logic [2:0]            idx;
    logic [7:0]            offset_c;
    logic [7:0]            rd_c;
    logic [7:0]            cur_c;
    logic [7:0]            seg_c;
    logic [NUM_DIGITS-1:0] an_c;
    logic                  lit_c;
    logic                  unused_read_strobe;

`ifdef DISPLAY_MUX_BRIGHTNESS_EN
    localparam int unsigned TW = PW + 4;
    logic [3:0]    bright;
    logic [TW-1:0] thresh_c;
`endif

    assign unused_read_strobe = read_strobe;
    assign offset_c = port_id - BASE_ADDRESS;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
        endcase
    endfunction

    // Register writes; reset wins over a coincident write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) digit[i] <= 8'h00;
            en     <= 1'b0;
            decode <= 1'b0;
            blank  <= '0;
`ifdef DISPLAY_MUX_BRIGHTNESS_EN
            bright <= 4'hF;
`endif
        end else if (write_strobe) begin
            case (offset_c)
                8'd8: begin
                    en     <= data_in[0];
                    decode <= data_in[1];
                end
                8'd9: blank <= data_in[NUM_DIGITS-1:0];
`ifdef DISPLAY_MUX_BRIGHTNESS_EN
                8'd10: bright <= data_in[3:0];
`endif
                default: begin
                    if (offset_c < 8'(NUM_DIGITS)) digit[offset_c[2:0]] <= data_in;
                end
            endcase
        end
    end

    // Scan prescaler and digit index, parked at zero while disabled.
    always_ff @(posedge clk) begin
        if (reset || !en) begin
            presc <= '0;
            idx   <= 3'd0;
        end else if (presc == PW'(SCAN_DIV - 1)) begin
            presc <= '0;
            idx   <= (idx == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx + 3'd1;
        end else begin
            presc <= presc + PW'(1);
        end
    end

`ifdef DISPLAY_MUX_BRIGHTNESS_EN
    // Product fits in PW+4 bits since bright <= 15 and SCAN_DIV <= 2**PW.
    assign thresh_c = (TW'(bright) * TW'(SCAN_DIV)) >> 4;
    assign lit_c    = TW'(presc) < thresh_c;
`else
    assign lit_c = 1'b1;
`endif

    // Active-high segment/anode pattern for the current slot.
    always_comb begin
        cur_c = digit[idx];
        seg_c = decode ? {cur_c[7], hex7(cur_c[3:0])} : cur_c;
        an_c  = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            an_c[i] = (idx == 3'(i)) && !blank[i] && lit_c;
        end
        if (!en) begin
            seg_c = 8'h00;
            an_c  = '0;
        end
    end

    always_comb begin
        rd_c = 8'h00;
        case (offset_c)
            8'd8:  rd_c = {6'b0, decode, en};
            8'd9:  rd_c = 8'(blank);
`ifdef DISPLAY_MUX_BRIGHTNESS_EN
            8'd10: rd_c = {4'b0, bright};
`endif
            8'd11: rd_c = {en, 4'b0, idx};
            default: begin
                if (offset_c < 8'(NUM_DIGITS)) rd_c = digit[offset_c[2:0]];
            end
        endcase
    end

    // Registered outputs with polarity applied last.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out <= 8'h00;
            segments <= {8{ACTIVE_LOW}};
            anodes   <= {NUM_DIGITS{ACTIVE_LOW}};
        end else begin
            data_out <= rd_c;
            segments <= seg_c ^ {8{ACTIVE_LOW}};
            anodes   <= an_c ^ {NUM_DIGITS{ACTIVE_LOW}};
        end
    end

endmodule

// File: tb/tb_display_mux_regs.sv
// Randomised bench for display_mux_regs against a cycle-count based reference model.
module tb_display_mux_regs;

    localparam logic [7:0]  BASE = 8'h40;
    localparam int unsigned ND   = 4;
    localparam int unsigned SD   = 4;
    localparam logic [6:0]  HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    port_id = 8'h00;
    logic [7:0]    data_in = 8'h00;
    logic [7:0]    data_out;
    logic          read_strobe = 1'b0;
    logic          write_strobe = 1'b0;
    logic [7:0]    segments;
    logic [ND-1:0] anodes;

    int checks = 0;
    int failures = 0;

    // Reference state: registers plus the number of enabled edges since EN rose.
    logic [7:0] m_digit [ND];
    bit         m_en;
    bit         m_dec;
    logic [3:0] m_blank;
    logic [3:0] m_bright;
    int         m_cyc;

    display_mux_regs #(
        .BASE_ADDRESS(BASE),
        .NUM_DIGITS  (ND),
        .SCAN_DIV    (SD),
        .ACTIVE_LOW  (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .port_id     (port_id),
        .data_in     (data_in),
        .data_out    (data_out),
        .read_strobe (read_strobe),
        .write_strobe(write_strobe),
        .segments    (segments),
        .anodes      (anodes)
    );

    always #5 clk = ~clk;

    task automatic check8(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_read(input logic [7:0] pid);
        int off;
        off = int'(pid) - int'(BASE);
        if (off >= 0 && off < int'(ND)) return m_digit[off];
        if (off == 8) return {6'b0, m_dec, m_en};
        if (off == 9) return {4'b0, m_blank};
`ifdef DISPLAY_MUX_BRIGHTNESS_EN
        if (off == 10) return {4'b0, m_bright};
`endif
        if (off == 11) return {m_en, 4'b0, 3'((m_cyc / SD) % ND)};
        return 8'h00;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ND; i++) m_digit[i] = 8'h00;
        m_en = 0; m_dec = 0; m_blank = 4'h0; m_bright = 4'hF; m_cyc = 0;
    endtask

    // One clock: drive inputs, predict outputs from pre-edge state, advance model, compare.
    task automatic step(input bit rst, input bit ws, input logic [7:0] pid, input logic [7:0] din);
        logic [7:0] e_seg, e_do, raw, d;
        logic [3:0] e_an;
        int idx, presc, off;
        bit lit;
        @(negedge clk);
        reset = rst; write_strobe = ws; port_id = pid; data_in = din;
        read_strobe = 1'($urandom % 2);
        idx = (m_cyc / SD) % ND;
        presc = m_cyc % SD;
`ifdef DISPLAY_MUX_BRIGHTNESS_EN
        lit = presc < (int'(m_bright) * SD) / 16;
`else
        lit = 1;
`endif
        d = m_digit[idx];
        raw = m_dec ? {d[7], HEX[d[3:0]]} : d;
        e_seg = m_en ? ~raw : 8'hFF;
        e_an = (m_en && !m_blank[idx] && lit) ? ~(4'b0001 << idx) : 4'hF;
        e_do = model_read(pid);
        if (rst) begin
            e_seg = 8'hFF; e_an = 4'hF; e_do = 8'h00;
            model_reset();
        end else begin
            m_cyc = m_en ? m_cyc + 1 : 0;
            off = int'(pid) - int'(BASE);
            if (ws) begin
                if (off >= 0 && off < int'(ND)) m_digit[off] = din;
                else if (off == 8) begin m_en = din[0]; m_dec = din[1]; end
                else if (off == 9) m_blank = din[3:0];
`ifdef DISPLAY_MUX_BRIGHTNESS_EN
                else if (off == 10) m_bright = din[3:0];
`endif
            end
        end
        @(posedge clk);
        #1;
        check8("segments", segments, e_seg);
        check8("anodes", 8'(anodes), 8'(e_an));
        check8("data_out", data_out, e_do);
    endtask

    task automatic idle(input int n, input logic [7:0] pid);
        for (int i = 0; i < n; i++) step(0, 0, pid, 8'h00);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 2000000", $time);
        $fatal(1);
    end

    initial begin
        model_reset();
        // Reset and basic readback.
        step(1, 0, 8'h48, 8'h00);
        step(1, 0, 8'h48, 8'h00);
        check8("rst_segments", segments, 8'hFF);
        check8("rst_anodes", 8'(anodes), 8'h0F);
        idle(2, 8'h48);

        // Decode scan of 01,02,03,8A.
        step(0, 1, 8'h40, 8'h01);
        step(0, 1, 8'h41, 8'h02);
        step(0, 1, 8'h42, 8'h03);
        step(0, 1, 8'h43, 8'h8A);
        step(0, 1, 8'h48, 8'h03);
        idle(1, 8'h4B);
        check8("plan_seg_d0", segments, 8'hF9);
        check8("plan_an_d0", 8'(anodes), 8'h0E);
        idle(12, 8'h4B);
        check8("plan_seg_d3", segments, 8'h08);
        check8("plan_an_d3", 8'(anodes), 8'h07);
        idle(8, 8'h4B);

        // Raw mode with digit 1 blanked, then unblanked.
        step(0, 1, 8'h48, 8'h01);
        step(0, 1, 8'h41, 8'h5C);
        step(0, 1, 8'h49, 8'h02);
        idle(18, 8'h49);
        step(0, 1, 8'h49, 8'h00);
        idle(18, 8'h41);

        // Readback of digit, unmapped, BLANK, STATUS, BRIGHT window.
        step(0, 1, 8'h49, 8'h05);
        idle(1, 8'h40); idle(1, 8'h44); idle(1, 8'h49); idle(1, 8'h4B); idle(1, 8'h4A);
        idle(1, 8'h4A);
`ifndef DISPLAY_MUX_BRIGHTNESS_EN
        check8("plan_bright_unmapped", data_out, 8'h00);
`endif
        step(0, 1, 8'h49, 8'h00);

        // Boundary: write digit 0 during its own slot, clear EN mid-slot.
        step(0, 1, 8'h48, 8'h00);
        step(0, 1, 8'h48, 8'h03);
        step(0, 1, 8'h40, 8'h0E);
        idle(3, 8'h4B);
        idle(5, 8'h4B);
        step(0, 1, 8'h48, 8'h02);
        idle(3, 8'h4B);
        check8("plan_status_off", data_out, 8'h00);

        // Reset coinciding with a write.
        step(1, 1, 8'h40, 8'h55);
        idle(2, 8'h40);
        check8("plan_rst_write", data_out, 8'h00);

`ifdef DISPLAY_MUX_BRIGHTNESS_EN
        step(0, 1, 8'h48, 8'h01);
        step(0, 1, 8'h4A, 8'h04);
        idle(16, 8'h4A);
        step(0, 1, 8'h4A, 8'h00);
        idle(16, 8'h4A);
`endif

        // Randomised traffic, EN biased towards on.
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] pid, din;
            bit ws, rst;
            pid = ($urandom % 8 == 0) ? 8'($urandom) : BASE + 8'($urandom % 12);
            din = 8'($urandom);
            if (pid == 8'h48) din[0] = ($urandom % 4) != 0;
            ws  = ($urandom % 3) == 0;
            rst = ($urandom % 300) == 0;
            step(rst, ws, pid, din);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
